// File: rtl/line_filler_pkg.sv
// Shared video constants: bus/line-buffer widths and the line filler state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package line_filler_pkg;

    // Video memory word-address width (bits [AW:1] of the byte address).
    localparam int VID_AW  = 23;
    // Line-buffer address width; also used by the shifter feeder.
    localparam int VID_LBW = 9;
    // Video memory data width.
    localparam int VID_DW  = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } lf_state_t;

endpackage

// File: rtl/line_filler.sv
// Fetches one scanline of pixel words from video memory into line-buffer addresses 0..N-1.
// Latency: bus opens 1 cycle after start_i; each line-buffer write is visible 1 cycle after its ack.
// Backpressure: the bus slave stretches each transfer via m_ack_i (unbounded waits); start_i while busy is dropped and flagged on overrun_o.
//
// Ports:
//   dotclk_i/reset_n_i        clock and synchronous active-low reset
//   start_i, line_words_i     per-line fetch trigger and length (0 = no fetch)
//   vsync_i, fb_base_i        frame pointer reload; aborts any fetch in flight
//   m_*                       classic single-master read bus
//   s_adr_o/s_dat_o/s_we_o    line-buffer write port
//   busy_o, overrun_o         fetch in progress; sticky start-while-busy flag
module line_filler
    import line_filler_pkg::*;
#(
    parameter int AW  = VID_AW,
    parameter int LBW = VID_LBW
) (
    input  logic              dotclk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              vsync_i,
    input  logic [AW-1:0]     fb_base_i,
    input  logic [LBW-1:0]    line_words_i,
    output logic [AW-1:0]     m_adr_o,
    output logic              m_cyc_o,
    output logic              m_stb_o,
    input  logic              m_ack_i,
    input  logic [VID_DW-1:0] m_dat_i,
    output logic [LBW-1:0]    s_adr_o,
    output logic [VID_DW-1:0] s_dat_o,
    output logic              s_we_o,
    output logic              busy_o,
    output logic              overrun_o
);

    lf_state_t         state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;        // frame read pointer (start of next line)
    logic [AW-1:0]     adr_q, adr_d;        // bus address of the current word
    logic [LBW-1:0]    idx_q, idx_d;        // line-buffer index of the current word
    logic [LBW-1:0]    rem_q, rem_d;        // words still to fetch, including current
    logic [LBW-1:0]    s_adr_q, s_adr_d;
    logic [VID_DW-1:0] s_dat_q, s_dat_d;
    logic              s_we_q, s_we_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        adr_d     = adr_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        s_adr_d   = s_adr_q;
        s_dat_d   = s_dat_q;
        s_we_d    = 1'b0;
        overrun_d = overrun_q;

        if (vsync_i) begin
            // vsync wins over everything: abort, reload, and discard any
            // coincident ack or start (a dropped start is not an overrun).
            state_d   = ST_IDLE;
            ptr_d     = fb_base_i;
            overrun_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i && (line_words_i != '0)) begin
                        state_d = ST_FETCH;
                        adr_d   = ptr_q;
                        idx_d   = '0;
                        rem_d   = line_words_i;
                    end
                end
                ST_FETCH: begin
                    if (start_i) begin
                        overrun_d = 1'b1;
                    end
                    if (m_ack_i) begin
                        s_dat_d = m_dat_i;
                        s_adr_d = idx_q;
                        s_we_d  = 1'b1;
                        adr_d   = adr_q + AW'(1);
                        idx_d   = idx_q + LBW'(1);
                        rem_d   = rem_q - LBW'(1);
                        if (rem_q == LBW'(1)) begin
                            // adr_q started at ptr_q and advanced once per word,
                            // so adr_q+1 is ptr_q + line length modulo 2^AW.
                            state_d = ST_IDLE;
                            ptr_d   = adr_q + AW'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge dotclk_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            adr_q     <= '0;
            idx_q     <= '0;
            rem_q     <= '0;
            s_adr_q   <= '0;
            s_dat_q   <= '0;
            s_we_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            adr_q     <= adr_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            s_adr_q   <= s_adr_d;
            s_dat_q   <= s_dat_d;
            s_we_q    <= s_we_d;
            overrun_q <= overrun_d;
        end
    end

    // Bus strobes are a pure decode of the registered state, so they rise and
    // fall on the same edge as the state change and stay held through waits.
    assign m_cyc_o   = (state_q == ST_FETCH);
    assign m_stb_o   = (state_q == ST_FETCH);
    assign busy_o    = (state_q == ST_FETCH);
    assign m_adr_o   = adr_q;
    assign s_adr_o   = s_adr_q;
    assign s_dat_o   = s_dat_q;
    assign s_we_o    = s_we_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_line_filler.sv
// Self-checking bench for line_filler: vector table of line fetches plus random lines and a mid-fetch reset.
// Latency: expects bus open 1 cycle after start, each write 1 cycle after its ack.
// Backpressure: the bench acts as the bus slave with random wait states.
module tb_line_filler;

    logic        dotclk_i = 1'b0;
    logic        reset_n_i;
    logic        start_i;
    logic        vsync_i;
    logic [22:0] fb_base_i;
    logic [8:0]  line_words_i;
    logic [22:0] m_adr_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_ack_i;
    logic [15:0] m_dat_i;
    logic [8:0]  s_adr_o;
    logic [15:0] s_dat_o;
    logic        s_we_o;
    logic        busy_o;
    logic        overrun_o;

    line_filler dut (
        .dotclk_i    (dotclk_i),
        .reset_n_i   (reset_n_i),
        .start_i     (start_i),
        .vsync_i     (vsync_i),
        .fb_base_i   (fb_base_i),
        .line_words_i(line_words_i),
        .m_adr_o     (m_adr_o),
        .m_cyc_o     (m_cyc_o),
        .m_stb_o     (m_stb_o),
        .m_ack_i     (m_ack_i),
        .m_dat_i     (m_dat_i),
        .s_adr_o     (s_adr_o),
        .s_dat_o     (s_dat_o),
        .s_we_o      (s_we_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    always #5 dotclk_i = ~dotclk_i;

    int checks   = 0;
    int failures = 0;

    // Reference state: where the next line should start, and the sticky flag.
    logic [22:0] ptr_m;
    logic        overrun_m;

    typedef struct {
        logic        pre_vsync;   // pulse vsync with fb before the line
        logic [22:0] fb;
        int          n;           // line_words_i
        int          maxw;        // max wait states per word
        int          start_at;    // word index whose ack cycle also carries start_i (-1 none)
        int          vsync_at;    // word index whose ack cycle also carries vsync_i (-1 none)
        logic [22:0] vbase;
        logic [22:0] exp_first;   // expected first bus address
        int          exp_wr;      // expected number of line-buffer writes
    } vec_t;

    vec_t vecs[9];

    // Video memory contents as a function of word address.
    function automatic logic [15:0] mem(input logic [22:0] a);
        logic [15:0] m;
        m = a[15:0] * 16'h9E37;
        return m ^ {9'h0, a[22:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge dotclk_i);
        @(negedge dotclk_i);
    endtask

    task automatic do_vsync(input logic [22:0] fb);
        vsync_i   = 1'b1;
        fb_base_i = fb;
        tick();
        vsync_i   = 1'b0;
        ptr_m     = fb;
        overrun_m = 1'b0;
        chk("vsync_overrun", {31'b0, overrun_o}, {31'b0, overrun_m});
        chk("vsync_busy", {31'b0, busy_o}, 32'd0);
    endtask

    // Fetch one line acting as bus slave; checks every cycle against the model.
    task automatic run_line(input int n, input int maxw, input int start_at, input int vsync_at,
                            input logic [22:0] vbase, output logic [22:0] first, output int wr);
        logic [22:0] base;
        int w;
        base  = ptr_m;
        wr    = 0;
        first = '0;
        line_words_i = 9'(n);
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        if (n == 0) begin
            chk("zero_cyc", {31'b0, m_cyc_o}, 32'd0);
            m_ack_i = 1'b1;            // stray ack while idle must be ignored
            tick();
            m_ack_i = 1'b0;
            chk("zero_we", {31'b0, s_we_o}, 32'd0);
            chk("zero_busy", {31'b0, busy_o}, 32'd0);
            return;
        end
        first = m_adr_o;
        chk("open_busy", {31'b0, busy_o}, 32'd1);
        for (int k = 0; k < n; k++) begin
            w = $urandom_range(0, maxw);
            for (int j = 0; j <= w; j++) begin
                chk("bus_cyc_stb", {30'b0, m_cyc_o, m_stb_o}, 32'd3);
                chk("bus_adr", {9'b0, m_adr_o}, {9'b0, base + 23'(k)});
                if (j < w) begin
                    tick();
                    chk("wait_no_we", {31'b0, s_we_o}, 32'd0);
                end
            end
            m_ack_i = 1'b1;
            m_dat_i = mem(m_adr_o);
            if (k == vsync_at) begin
                vsync_i   = 1'b1;
                fb_base_i = vbase;
            end
            if (k == start_at) start_i = 1'b1;
            tick();
            m_ack_i = 1'b0;
            start_i = 1'b0;
            if (k == vsync_at) begin
                vsync_i   = 1'b0;
                ptr_m     = vbase;
                overrun_m = 1'b0;
                chk("abort_no_we", {31'b0, s_we_o}, 32'd0);
                chk("abort_cyc", {31'b0, m_cyc_o}, 32'd0);
                chk("abort_busy", {31'b0, busy_o}, 32'd0);
                return;
            end
            if (k == start_at) overrun_m = 1'b1;
            chk("wr_we", {31'b0, s_we_o}, 32'd1);
            if (s_we_o) wr++;
            chk("wr_adr", {23'b0, s_adr_o}, k);
            chk("wr_dat", {16'b0, s_dat_o}, {16'b0, mem(base + 23'(k))});
            chk("overrun", {31'b0, overrun_o}, {31'b0, overrun_m});
        end
        chk("end_busy", {31'b0, busy_o}, 32'd0);
        chk("end_cyc", {31'b0, m_cyc_o}, 32'd0);
        ptr_m = base + 23'(n);
        tick();
        chk("end_no_we", {31'b0, s_we_o}, 32'd0);
    endtask

    initial begin
        logic [22:0] first;
        int          wr;

        //          pre  fb         n    maxw st  vs  vbase      first      wr
        vecs[0] = '{1'b1, 23'h001000, 4,   0, -1, -1, 23'h0,      23'h001000, 4};
        vecs[1] = '{1'b0, 23'h0,      4,   0, -1, -1, 23'h0,      23'h001004, 4};
        vecs[2] = '{1'b0, 23'h0,      40,  5, -1, -1, 23'h0,      23'h001008, 40};
        vecs[3] = '{1'b0, 23'h0,      40,  2, 10, -1, 23'h0,      23'h001030, 40};
        vecs[4] = '{1'b1, 23'h003000, 20,  1, -1,  4, 23'h002000, 23'h003000, 4};
        vecs[5] = '{1'b0, 23'h0,      0,   0, -1, -1, 23'h0,      23'h0,      0};
        vecs[6] = '{1'b0, 23'h0,      511, 0, -1, -1, 23'h0,      23'h002000, 511};
        vecs[7] = '{1'b1, 23'h7FFFFE, 4,   3, -1, -1, 23'h0,      23'h7FFFFE, 4};
        vecs[8] = '{1'b0, 23'h0,      1,   0, -1, -1, 23'h0,      23'h000002, 1};

        reset_n_i = 1'b0; start_i = 1'b0; vsync_i = 1'b0; fb_base_i = '0;
        line_words_i = '0; m_ack_i = 1'b0; m_dat_i = '0;
        ptr_m = '0; overrun_m = 1'b0;
        tick();
        tick();
        chk("rst_outputs", {m_adr_o, m_cyc_o, m_stb_o, s_we_o, busy_o, overrun_o}, 32'd0);
        chk("rst_sdat", {7'b0, s_adr_o, s_dat_o}, 32'd0);
        reset_n_i = 1'b1;
        tick();

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].pre_vsync) do_vsync(vecs[v].fb);
            run_line(vecs[v].n, vecs[v].maxw, vecs[v].start_at, vecs[v].vsync_at,
                     vecs[v].vbase, first, wr);
            if (vecs[v].n != 0) chk("vec_first_adr", {9'b0, first}, {9'b0, vecs[v].exp_first});
            chk("vec_writes", wr, vecs[v].exp_wr);
            if (v == 3) chk("overrun_sticky", {31'b0, overrun_o}, 32'd1);
        end

        // Random lines from a random base.
        do_vsync(23'($urandom));
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 30);
            run_line(n, $urandom_range(0, 4), -1, -1, 23'h0, first, wr);
            chk("rand_writes", wr, n);
        end

        // Reset in the middle of a fetch: bus drops, no further writes.
        line_words_i = 9'd10;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        m_ack_i = 1'b1;
        m_dat_i = 16'hBEEF;
        tick();
        reset_n_i = 1'b0;
        tick();
        chk("midrst_cyc", {30'b0, m_cyc_o, busy_o}, 32'd0);
        chk("midrst_we", {31'b0, s_we_o}, 32'd0);
        reset_n_i = 1'b1;
        tick();
        chk("midrst_we2", {31'b0, s_we_o}, 32'd0);
        m_ack_i = 1'b0;
        ptr_m = '0;
        overrun_m = 1'b0;
        run_line(2, 0, -1, -1, 23'h0, first, wr);
        chk("after_rst_adr", {9'b0, first}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
